// File: rtl/divide_fsm_8bit_if.sv
// Handshake and data bundle shared by the divider and whoever drives it.
// The master side supplies operands and the start request; the slave side
// (the divider) returns the quotient, remainder and status flags.
interface divide_fsm_8bit_if #(
  parameter int WIDTH = 8
);
  logic             enter;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             done;
  logic             div_by_zero;

  modport master (
    output enter, A, B,
    input  Q, R, done, div_by_zero
  );

  modport slave (
    input  enter, A, B,
    output Q, R, done, div_by_zero
  );
endinterface

// File: rtl/divide_fsm_8bit.sv
// Sequential restoring divider. Captures A/B on enter, produces one quotient
// bit per clock (MSB first) and pulses done for one cycle when Q/R are valid.
// Divide by zero takes the normal path and yields Q = all ones, R = A.
module divide_fsm_8bit #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  divide_fsm_8bit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    START = 2'd1,
    ITER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           ps_q, ps_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic [WIDTH:0]   pr_q, pr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             qbit;

  // Trial subtraction is done one bit wider than the operands so the carry
  // out of the shifted partial remainder is never lost.
  assign trial = {pr_q[WIDTH-1:0], dq_q[WIDTH-1]};
  assign diff  = trial - {1'b0, dv_q};
  assign qbit  = (trial >= {1'b0, dv_q});

  // Next-state and datapath updates for every FSM state.
  always_comb begin
    ps_d  = ps_q;
    dq_d  = dq_q;
    dv_d  = dv_q;
    pr_d  = pr_q;
    cnt_d = cnt_q;
    q_d   = q_q;
    r_d   = r_q;
    dbz_d = dbz_q;
    case (ps_q)
      HOLD: begin
        if (bus.enter) begin
          dq_d  = bus.A;
          dv_d  = bus.B;
          dbz_d = (bus.B == '0);
          ps_d  = START;
        end
      end
      START: begin
        pr_d  = '0;
        cnt_d = CW'(WIDTH - 1);
        q_d   = '0;
        r_d   = '0;
        ps_d  = ITER;
      end
      ITER: begin
        pr_d = qbit ? diff : trial;
        dq_d = {dq_q[WIDTH-2:0], qbit};
        if (cnt_q == '0) begin
          q_d  = {dq_q[WIDTH-2:0], qbit};
          r_d  = pr_d[WIDTH-1:0];
          ps_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        ps_d = HOLD;
      end
      default: begin
        ps_d = HOLD;
      end
    endcase
    done_d = (ps_d == DONE);
  end

  // State and output registers; reset takes priority and aborts any division.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q   <= HOLD;
      dq_q   <= '0;
      dv_q   <= '0;
      pr_q   <= '0;
      cnt_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      dbz_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      dq_q   <= dq_d;
      dv_q   <= dv_d;
      pr_q   <= pr_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      r_q    <= r_d;
      dbz_q  <= dbz_d;
      done_q <= done_d;
    end
  end

  assign bus.Q           = q_q;
  assign bus.R           = r_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divide_fsm_8bit.sv
// Self-checking bench for divide_fsm_8bit: a cycle-count model of the divider
// computes expected outputs with plain integer division, and a compare
// process checks every output each cycle; directed runs pin literal results.
module tb_divide_fsm_8bit;

  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH + 2;

  logic clk;
  logic reset;

  divide_fsm_8bit_if #(.WIDTH(WIDTH)) bus ();

  divide_fsm_8bit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks;
  int errors;
  bit compare_on;

  // Behavioural model state: phase counts cycles since capture (0 = idle).
  int         m_phase;
  bit         m_valid;
  logic [7:0] m_a, m_b, m_q, m_r;
  logic       m_dbz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: what the outputs must be after each clock edge.
  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_q     = 8'd0;
      m_r     = 8'd0;
      m_dbz   = 1'b0;
      m_valid = 1'b1;
    end else if (m_phase == 0) begin
      if (bus.enter === 1'b1) begin
        m_a     = bus.A;
        m_b     = bus.B;
        m_dbz   = (bus.B == 8'd0);
        m_phase = 1;
      end
    end else begin
      m_phase++;
      if (m_phase == 2) begin
        m_q = 8'd0;
        m_r = 8'd0;
      end else if (m_phase == LAT) begin
        m_q = (m_b == 8'd0) ? 8'hFF : 8'(m_a / m_b);
        m_r = (m_b == 8'd0) ? m_a   : 8'(m_a % m_b);
      end else if (m_phase == LAT + 1) begin
        m_phase = 0;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (compare_on && m_valid) begin
      checkOutput("cyc_done", int'(bus.done), int'(m_phase == LAT));
      checkOutput("cyc_Q", int'(bus.Q), int'(m_q));
      checkOutput("cyc_R", int'(bus.R), int'(m_r));
      checkOutput("cyc_div_by_zero", int'(bus.div_by_zero), int'(m_dbz));
    end
  end

  // One division with literal expectations; optionally wiggles enter while busy.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input int exp_q, input int exp_r, input int exp_dbz,
                               input bit toggle);
    int lat;
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.enter = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 3 * LAT; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      if (k == 1) begin
        bus.enter = 1'b0;
        bus.A     = 8'($urandom);
        bus.B     = 8'($urandom);
      end else if (toggle) begin
        bus.enter = 1'($urandom_range(0, 1));
      end
    end
    bus.enter = 1'b0;
    checkOutput("latency", lat, LAT);
    checkOutput("lit_Q", int'(bus.Q), exp_q);
    checkOutput("lit_R", int'(bus.R), exp_r);
    checkOutput("lit_div_by_zero", int'(bus.div_by_zero), exp_dbz);
    checkOutput("model_Q", int'(m_q), exp_q);
    checkOutput("model_R", int'(m_r), exp_r);
  endtask

  initial begin
    int saw_done;
    int first_done;
    int second_done;

    checks      = 0;
    errors      = 0;
    compare_on  = 1'b1;
    m_phase     = 0;
    m_valid     = 1'b0;
    reset       = 1'b1;
    bus.enter   = 1'b0;
    bus.A       = 8'd0;
    bus.B       = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    checkOutput("reset_Q", int'(bus.Q), 0);
    checkOutput("reset_R", int'(bus.R), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_div_by_zero", int'(bus.div_by_zero), 0);

    applyStimulus(8'd100, 8'd7,   14,  2,   0, 1'b0);
    applyStimulus(8'd255, 8'd1,   255, 0,   0, 1'b0);
    applyStimulus(8'd255, 8'd255, 1,   0,   0, 1'b0);
    applyStimulus(8'd5,   8'd9,   0,   5,   0, 1'b0);
    applyStimulus(8'd200, 8'd0,   255, 200, 1, 1'b0);
    applyStimulus(8'd9,   8'd3,   3,   0,   0, 1'b0);
    applyStimulus(8'd0,   8'd0,   255, 0,   1, 1'b1);
    applyStimulus(8'd123, 8'd10,  12,  3,   0, 1'b1);

    // Reset in the middle of an iteration aborts without a done pulse.
    @(negedge clk);
    bus.A     = 8'd50;
    bus.B     = 8'd5;
    bus.enter = 1'b1;
    @(posedge clk);
    saw_done = 0;
    for (int k = 1; k <= 2 * LAT; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1;
      if (k == 1) bus.enter = 1'b0;
      if (k == 4) reset = 1'b1;
      if (k == 5) reset = 1'b0;
    end
    checkOutput("abort_no_done", saw_done, 0);
    checkOutput("abort_Q", int'(bus.Q), 0);
    checkOutput("abort_R", int'(bus.R), 0);
    applyStimulus(8'd50, 8'd5, 10, 0, 0, 1'b0);

    // Enter held high: back-to-back divisions, operands swapped mid-flight.
    @(negedge clk);
    bus.A     = 8'd100;
    bus.B     = 8'd7;
    bus.enter = 1'b1;
    @(posedge clk);
    first_done  = 0;
    second_done = 0;
    for (int k = 1; k <= 3 * LAT; k++) begin
      @(negedge clk);
      if (k == 2) begin
        bus.A = 8'd17;
        bus.B = 8'd4;
      end
      if (bus.done === 1'b1) begin
        if (first_done == 0) begin
          first_done = k;
          checkOutput("b2b_first_Q", int'(bus.Q), 14);
          checkOutput("b2b_first_R", int'(bus.R), 2);
        end else begin
          second_done = k;
          checkOutput("b2b_second_Q", int'(bus.Q), 4);
          checkOutput("b2b_second_R", int'(bus.R), 1);
          break;
        end
      end
    end
    bus.enter = 1'b0;
    checkOutput("b2b_first_cycle", first_done, 10);
    checkOutput("b2b_second_cycle", second_done, 21);

    // Randomised traffic with occasional resets, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 149) == 0);
      bus.enter = ($urandom_range(0, 2) == 0);
      bus.A     = 8'($urandom);
      bus.B     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
    end
    @(negedge clk);
    reset     = 1'b0;
    bus.enter = 1'b0;
    repeat (2 * LAT) @(negedge clk);

    compare_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
